// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared state encoding, sample type and accumulator sizing for the I2S transmitter
package i2s_pkg;

  localparam int I2S_BITS = 24;

  typedef logic [I2S_BITS-1:0] i2s_sample_t;

  typedef enum logic [1:0] {
    I2S_IDLE  = 2'd0,
    I2S_RUN   = 2'd1,
    I2S_DRAIN = 2'd2
  } i2s_state_t;

  // Wide enough for acc + step before the subtract, so the accumulator never wraps.
  function automatic int i2s_acc_width(input longint clk_hz, input longint step);
    return $clog2(clk_hz + step);
  endfunction

endpackage

// File: rtl/i2s_tx_sequencer_if.sv
// rtl/i2s_tx_sequencer_if.sv - stereo sample valid/ready handshake between the sample source and the I2S transmitter
interface i2s_tx_sequencer_if #(
  parameter int BITS = 24
);
  logic            s_valid;
  logic            s_ready;
  logic [BITS-1:0] s_left;
  logic [BITS-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input  s_ready);
  modport slave  (input  s_valid, input  s_left, input  s_right, output s_ready);
endinterface

// File: rtl/i2s_frac_div.sv
// rtl/i2s_frac_div.sv - exact fractional edge generator: tick whenever acc + STEP crosses CLK_HZ
module i2s_frac_div
  import i2s_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int STEP   = 4_233_600
) (
  input  logic clk_ref,
  input  logic reset,
  input  logic run_i,
  output logic tick_o
);
  localparam int          W      = i2s_acc_width(CLK_HZ, STEP);
  localparam logic [W-1:0] STEP_W = W'(STEP);
  localparam logic [W-1:0] CLK_W  = W'(CLK_HZ);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [W-1:0] sum;

  // Holding acc at zero while stopped makes the first edge after start deterministic.
  always_comb begin
    sum    = acc_q + STEP_W;
    tick_o = run_i && (sum >= CLK_W);
    acc_d  = '0;
    if (run_i) begin
      acc_d = tick_o ? (sum - CLK_W) : sum;
    end
  end

  always_ff @(posedge clk_ref or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// rtl/i2s_tx_sequencer.sv - I2S Philips-format transmitter: BCK/WS generation, 1-deep sample buffer, serializer
// Defining I2S_MCLK_EN adds a free-running i2s_mclk output at 256*FS_HZ.
module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int FS_HZ  = 44_100,
  parameter int BITS   = 24
) (
  input  logic              clk_ref,
  input  logic              reset,
  input  logic              enable,
  i2s_tx_sequencer_if.slave smp,
  output logic              i2s_bck,
  output logic              i2s_ws,
  output logic              i2s_sd,
  output logic              busy,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
`ifdef I2S_MCLK_EN
  ,
  output logic              i2s_mclk
`endif
);
  localparam int            STEP  = FS_HZ * BITS * 4;
  localparam int            FRAME = 2 * BITS;
  localparam int            CW    = $clog2(FRAME);
  localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);
  localparam logic [CW-1:0] WS_LO = CW'(BITS - 1);
  localparam logic [CW-1:0] WS_HI = CW'(FRAME - 2);

  localparam logic [1:0] ST_IDLE  = I2S_IDLE;
  localparam logic [1:0] ST_RUN   = I2S_RUN;
  localparam logic [1:0] ST_DRAIN = I2S_DRAIN;

  logic [1:0]       state_q, state_d;
  logic             bck_q, bck_d;
  logic             ws_q, ws_d;
  logic             sd_q, sd_d;
  logic [FRAME-1:0] frame_q, frame_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             empty_q, empty_d;
  logic [BITS-1:0]  left_q, left_d;
  logic [BITS-1:0]  right_q, right_d;
  logic             under_q, under_d;
  logic [15:0]      ucnt_q, ucnt_d;
  logic             busy_q, busy_d;

  logic             running;
  logic             tick;
  logic             fall;
  logic             wrap;
  logic             drain_stop;
  logic             hs;
  logic [CW-1:0]    bit_nx;
  logic [FRAME-1:0] load;

  assign running = (state_q != ST_IDLE);

  i2s_frac_div #(
    .CLK_HZ (CLK_HZ),
    .STEP   (STEP)
  ) u_bck_div (
    .clk_ref (clk_ref),
    .reset   (reset),
    .run_i   (running),
    .tick_o  (tick)
  );

  always_comb begin
    fall       = tick && bck_q;
    bit_nx     = (bit_q == LAST) ? '0 : bit_q + 1'b1;
    wrap       = fall && (bit_nx == '0);
    hs         = smp.s_valid && empty_q;
    drain_stop = (state_q == ST_DRAIN) && !enable && fall && (bit_nx == LAST);

    state_d = state_q;
    bck_d   = bck_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    empty_d = empty_q;
    left_d  = left_q;
    right_d = right_q;
    under_d = 1'b0;
    ucnt_d  = ucnt_q;
    load    = '0;

    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (drain_stop) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    // Capture only ever happens into an empty buffer, so it cannot collide with a buffered frame-load.
    if (hs) begin
      left_d  = smp.s_left;
      right_d = smp.s_right;
      empty_d = 1'b0;
    end

    if (tick) begin
      bck_d = ~bck_q;
    end

    if (fall) begin
      bit_d = bit_nx;
      ws_d  = (bit_nx >= WS_LO) && (bit_nx <= WS_HI);
      if (wrap) begin
        if (empty_q) begin
          under_d = 1'b1;
          if (ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
          end
        end else begin
          load    = {left_q, right_q};
          empty_d = 1'b1;
        end
        sd_d    = load[FRAME-1];
        frame_d = {load[FRAME-2:0], 1'b0};
      end else begin
        sd_d    = frame_q[FRAME-1];
        frame_d = {frame_q[FRAME-2:0], 1'b0};
      end
      if (drain_stop) begin
        sd_d = 1'b0;
        ws_d = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_ref or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bck_q   <= 1'b0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      frame_q <= '0;
      bit_q   <= LAST;
      empty_q <= 1'b1;
      left_q  <= '0;
      right_q <= '0;
      under_q <= 1'b0;
      ucnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bck_q   <= bck_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      empty_q <= empty_d;
      left_q  <= left_d;
      right_q <= right_d;
      under_q <= under_d;
      ucnt_q  <= ucnt_d;
      busy_q  <= busy_d;
    end
  end

  assign smp.s_ready  = empty_q;
  assign i2s_bck      = bck_q;
  assign i2s_ws       = ws_q;
  assign i2s_sd       = sd_q;
  assign busy         = busy_q;
  assign underrun     = under_q;
  assign underrun_cnt = ucnt_q;

`ifdef I2S_MCLK_EN
  logic mclk_tick;
  logic mclk_q;

  i2s_frac_div #(
    .CLK_HZ (CLK_HZ),
    .STEP   (FS_HZ * 512)
  ) u_mclk_div (
    .clk_ref (clk_ref),
    .reset   (reset),
    .run_i   (running),
    .tick_o  (mclk_tick)
  );

  // Cleared from the next state so MCLK is already low in the first IDLE cycle.
  always_ff @(posedge clk_ref or negedge reset) begin
    if (!reset) begin
      mclk_q <= 1'b0;
    end else if (!busy_d) begin
      mclk_q <= 1'b0;
    end else if (mclk_tick) begin
      mclk_q <= ~mclk_q;
    end
  end

  assign i2s_mclk = mclk_q;
`endif

endmodule

// File: doc/i2s_tx_sequencer.md
# i2s_tx_sequencer

Sequences the I2S audio transmit path from the single `clk_ref` domain: derives bit clock (BCK) and word select (WS) with an exact fractional accumulator, and serializes 24-bit stereo samples in Philips I2S format. Takes stereo samples over a valid/ready handshake from the upstream mixer or FIFO, and inserts silence with an underrun flag when no sample is ready at a frame boundary. Sits between the sample FIFO and the DAC pins.

## Interface
- `CLK_HZ`, 100_000_000: `clk_ref` frequency.
- `FS_HZ`, 44_100: sample rate.
- `BITS`, 24: bits per channel slot; frame is 2*BITS BCK periods.
- `clk_ref` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: run request.
- `s_valid` in 1: stereo sample offered.
- `s_ready` out 1: holding buffer empty.
- `s_left` in BITS: left sample, two's complement.
- `s_right` in BITS: right sample, two's complement.
- `i2s_bck` out 1: bit clock.
- `i2s_ws` out 1: word select; 0 = left, 1 = right.
- `i2s_sd` out 1: serial data.
- `busy` out 1: high in RUN or DRAIN.
- `underrun` out 1: one-cycle pulse.
- `underrun_cnt` out 16: saturating underrun count.

## Operation
- Edge generator: accumulator `acc += STEP` every RUN/DRAIN cycle, where STEP = FS_HZ*BITS*4. When `acc + STEP >= CLK_HZ`, the cycle subtracts CLK_HZ and raises `tick` for one cycle.
  - The accumulator is ceil(log2(CLK_HZ+STEP)) bits wide, unsigned, and never negative.
  - Long-term edge rate is exact, with no drift.
  - Each `tick` toggles `i2s_bck`.
- Falling tick (BCK 1->0) advances `bit_cnt`: 0..2*BITS-1, wrapping to 0.
- On the wrap to 0:
  - If the buffer is full, load the 48-bit frame shift register with {left, right} and empty the buffer.
  - If the buffer is empty, load zeros, pulse `underrun`, and increment `underrun_cnt`, saturating at 0xFFFF.
- `i2s_sd` = frame[2*BITS-1-bit_cnt], updated on falling ticks only.
- `i2s_ws` = 1 when BITS-1 <= bit_cnt <= 2*BITS-2, else 0. WS therefore leads each channel MSB by one BCK.
- Holding buffer:
  - `s_ready` = !full.
  - A handshake (`s_valid & s_ready`) captures both channels and sets full.
  - Capture and frame-load in the same cycle is impossible, because `s_ready` = 0 while full.
  - Capture is accepted in every state, including IDLE.
- FSM:
  - IDLE: BCK = 0, `acc` = 0, `bit_cnt` = 2*BITS-1. Goes to RUN when `enable` = 1.
  - RUN: goes to DRAIN when `enable` = 0.
  - DRAIN: continues until the falling tick that makes `bit_cnt` = 2*BITS-1, then goes to IDLE. That tick also drives SD to 0 and WS to 0. The buffer keeps its contents.
  - If `enable` reasserts in DRAIN, return to RUN with no glitch.

## Timing
- Reset values:
  - `i2s_bck`, `i2s_ws`, `i2s_sd`: 0.
  - `s_ready`: 1.
  - `busy`, `underrun`: 0.
  - `underrun_cnt`: 0.
  - Buffer empty; FSM IDLE.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); the partial frame is discarded.
- First tick arrives ceil(CLK_HZ/STEP) cycles after RUN entry at most; it is rising. The first falling tick loads frame 0.
- All outputs are registered. `i2s_sd` and `i2s_ws` change in the same cycle as the falling BCK edge.
- `s_ready` rises the cycle after the frame-load that empties the buffer.
- `underrun` pulses in the frame-load cycle.
- BCK high/low durations differ by at most one `clk_ref` cycle (for the defaults, 23 or 24 cycles).

## Configuration
- `I2S_MCLK_EN` defined:
  - Adds output `i2s_mclk` (1 bit) at 256*FS_HZ, produced by a second identical accumulator with step FS_HZ*512.
  - It is free-running in RUN/DRAIN and held at 0 in IDLE and in reset.
- `I2S_MCLK_EN` undefined: the port and the logic are absent; behaviour is otherwise identical.

## Structure
- Package `i2s_pkg` holds:
  - the state enum `i2s_state_t` (IDLE, RUN, DRAIN);
  - the function `i2s_acc_width(clk_hz, step)`;
  - the sample type `i2s_sample_t` (BITS-wide logic).
- Sub-module `i2s_frac_div` holds the accumulator and `tick` logic. It is parameterized by CLK_HZ and STEP, and is instantiated once for BCK and once more under `I2S_MCLK_EN`.

## Test plan
- Basic frame:
  - Stimulus: reset, `enable` = 1, offer L = 0x800001, R = 0x7FFFFE.
  - Required: SD sequence MSB-first over 48 BCK periods, with WS = 0 from the falling edge before the left MSB. The bench decodes the frame back to the same values.
- Rate:
  - Stimulus: run 1,000,000 `clk_ref` cycles.
  - Required: falling-tick count = floor(1e6*4,233,600/2/1e8) ±1 = 21168 ±1.
  - Required: every BCK half-period is 23 or 24 cycles.
- Underrun:
  - Stimulus: supply no sample for 3 frames.
  - Required: SD all zeros, 3 `underrun` pulses, `underrun_cnt` = 3.
  - Required: the next valid sample is transmitted on the following frame.
- Backpressure:
  - Stimulus: hold `s_valid` = 1 continuously.
  - Required: exactly one handshake per 48 BCK periods, and no sample lost or duplicated across 10 frames.
- Drain/reset:
  - Stimulus: drop `enable` at `bit_cnt` = 10.
  - Required: the frame completes, then `busy` = 0 and BCK = 0.
  - Stimulus: assert `reset` mid-frame.
  - Required: all outputs are 0 and `s_ready` = 1 in the same cycle.
- `I2S_MCLK_EN`:
  - Required: 256 MCLK rising edges per WS period (±1), and MCLK is 0 in IDLE.
